// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write path.
package regfile_pkg;
  localparam int REG_ADDR_W = 2;
  localparam int REG_DATA_W = 8;
  localparam int NUM_REGS   = 4;

  // Requester ids; also the bit positions in request/grant vectors.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with one-hot grant.
// The last-grant state advances only on a real grant. It resets to B so that
// A wins the first conflict.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  logic r_last;

  // Pick the sole requester, or the one not served last time on a conflict.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == REQ_B) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Remember who was served; idle cycles leave the priority unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_last <= REQ_B;
    else if (|o_gnt) r_last <= o_gnt[REQ_B] ? REQ_B : REQ_A;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU (A) and load (B) writebacks.
// Each port has a one-entry holding buffer. A round-robin arbiter picks one
// buffer per cycle, and the winner is registered onto rf_we/rf_waddr/rf_wdata.
// Optional feature: define RF_WR_ARB_SCOREBOARD_EN to add the registered
// per-register 'pending' in-flight flags.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef RF_WR_ARB_SCOREBOARD_EN
  ,
  output logic [(2**ADDR_W)-1:0] pending
`endif
);
  logic              r_a_v, r_b_v;
  logic [ADDR_W-1:0] r_a_addr, r_b_addr;
  logic [DATA_W-1:0] r_a_data, r_b_data;

  logic [1:0]        w_req, w_gnt;
  logic              w_a_acc, w_b_acc;
  logic              w_a_v_nxt, w_b_v_nxt;
  logic [ADDR_W-1:0] w_a_addr_nxt, w_b_addr_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;

  // Flush masks the requests, so nothing is granted and last_grant holds.
  assign w_req = {r_b_v, r_a_v} & {2{~flush}};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (w_req),
    .o_gnt   (w_gnt)
  );

  // A buffer can take a new request when it is empty or draining this cycle.
  assign a_ready = !flush && (!r_a_v || w_gnt[REQ_A]);
  assign b_ready = !flush && (!r_b_v || w_gnt[REQ_B]);
  assign w_a_acc = a_valid && a_ready;
  assign w_b_acc = b_valid && b_ready;

  // Next-state of buffers and output stage, shared by the scoreboard.
  always_comb begin
    w_a_v_nxt    = flush ? 1'b0 : (w_a_acc | (r_a_v & ~w_gnt[REQ_A]));
    w_b_v_nxt    = flush ? 1'b0 : (w_b_acc | (r_b_v & ~w_gnt[REQ_B]));
    w_a_addr_nxt = w_a_acc ? a_addr : r_a_addr;
    w_b_addr_nxt = w_b_acc ? b_addr : r_b_addr;
    w_we_nxt     = |w_gnt;
    w_waddr_nxt  = rf_waddr;
    w_wdata_nxt  = rf_wdata;
    if (w_gnt[REQ_A]) begin
      w_waddr_nxt = r_a_addr;
      w_wdata_nxt = r_a_data;
    end else if (w_gnt[REQ_B]) begin
      w_waddr_nxt = r_b_addr;
      w_wdata_nxt = r_b_data;
    end
  end

  // Holding buffers: the payload is sampled only on the accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_v    <= 1'b0;
      r_b_v    <= 1'b0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_a_data <= '0;
      r_b_data <= '0;
    end else begin
      r_a_v    <= w_a_v_nxt;
      r_b_v    <= w_b_v_nxt;
      r_a_addr <= w_a_addr_nxt;
      r_b_addr <= w_b_addr_nxt;
      if (w_a_acc) r_a_data <= a_data;
      if (w_b_acc) r_b_data <= b_data;
    end
  end

  // Output stage: the write enable pulses per grant, and addr/data hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we    <= w_we_nxt;
      rf_waddr <= w_waddr_nxt;
      rf_wdata <= w_wdata_nxt;
    end
  end

`ifdef RF_WR_ARB_SCOREBOARD_EN
  localparam int NREG = 2**ADDR_W;
  logic [NREG-1:0] w_pend_nxt;

  // A register is pending while any holder (either buffer or output stage) targets it.
  always_comb begin
    w_pend_nxt = '0;
    if (w_a_v_nxt) w_pend_nxt = w_pend_nxt | (NREG'(1) << w_a_addr_nxt);
    if (w_b_v_nxt) w_pend_nxt = w_pend_nxt | (NREG'(1) << w_b_addr_nxt);
    if (w_we_nxt)  w_pend_nxt = w_pend_nxt | (NREG'(1) << w_waddr_nxt);
  end

  // Register the flags on the same edges as the holders they mirror.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= w_pend_nxt;
  end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. A small register-file model is
// written from the DUT write port.
module tb_regfile_write_arbiter;
  logic       clk = 1'b0;
  logic       reset_n, flush;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [1:0] a_addr, b_addr, rf_waddr;
  logic [7:0] a_data, b_data, rf_wdata;
  logic       rf_we;
`ifdef RF_WR_ARB_SCOREBOARD_EN
  logic [3:0] pending;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] rf_model [4];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
`ifdef RF_WR_ARB_SCOREBOARD_EN
    ,
    .pending  (pending)
`endif
  );

  // Register-file model: commits on the edge after rf_we is registered.
  always @(posedge clk) if (rf_we) rf_model[rf_waddr] <= rf_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf_model[i] = 8'h00;
    reset_n = 1'b0; flush = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #2;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
`ifdef RF_WR_ARB_SCOREBOARD_EN
    chk("rst_pending", pending, 0);
`endif
    step();
    reset_n = 1'b1;

    // Single uncontended write: 2 edges to register-file update.
    a_valid = 1'b1; a_addr = 2'd2; a_data = 8'h5A;
    step();                       // E0
    a_valid = 1'b0;
    chk("t1_we_e0", rf_we, 0);
`ifdef RF_WR_ARB_SCOREBOARD_EN
    chk("t1_pend_e0", pending, 4'b0100);
`endif
    step();                       // E1
    chk("t1_we_e1", rf_we, 1);
    chk("t1_waddr_e1", rf_waddr, 2);
    chk("t1_wdata_e1", rf_wdata, 8'h5A);
    step();                       // E2
    chk("t1_we_e2", rf_we, 0);
    chk("t1_waddr_hold", rf_waddr, 2);
    chk("t1_rf2", rf_model[2], 8'h5A);
`ifdef RF_WR_ARB_SCOREBOARD_EN
    chk("t1_pend_e2", pending, 0);
`endif

    // Conflict after reset: A first, then B.
    do_reset();
    a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 2'd3; b_data = 8'h33;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("t2_first_addr", rf_waddr, 1);
    chk("t2_first_data", rf_wdata, 8'h11);
    step();
    chk("t2_second_we", rf_we, 1);
    chk("t2_second_addr", rf_waddr, 3);
    chk("t2_second_data", rf_wdata, 8'h33);
    step();
    chk("t2_idle_we", rf_we, 0);
    chk("t2_rf3", rf_model[3], 8'h33);
    // A lone A write leaves last_grant = A, so the next conflict goes to B first.
    a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h12;
    step();
    a_valid = 1'b0;
    step(); step();
    a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h21;
    b_valid = 1'b1; b_addr = 2'd3; b_data = 8'h43;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("t2r_first_addr", rf_waddr, 3);
    chk("t2r_first_data", rf_wdata, 8'h43);
    step();
    chk("t2r_second_addr", rf_waddr, 1);
    chk("t2r_second_data", rf_wdata, 8'h21);
    step();
    chk("t2r_idle_we", rf_we, 0);

    // Same destination on both ports: the later grant (B) wins.
    do_reset();
    a_valid = 1'b1; a_addr = 2'd0; a_data = 8'hAA;
    b_valid = 1'b1; b_addr = 2'd0; b_data = 8'hBB;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("t3_first_data", rf_wdata, 8'hAA);
    step();
    chk("t3_second_data", rf_wdata, 8'hBB);
    step();
    chk("t3_rf0", rf_model[0], 8'hBB);

    // Sustained dual requests: strict alternation, and each ready is high every other cycle.
    do_reset();
    a_valid = 1'b1; a_addr = 2'd1; a_data = 8'hA1;
    b_valid = 1'b1; b_addr = 2'd2; b_data = 8'hB2;
    step();
    chk("t4_a_ready_0", a_ready, 1);
    chk("t4_b_ready_0", b_ready, 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t4_we", rf_we, 1);
      chk("t4_wdata", rf_wdata, (i % 2 == 1) ? 8'hA1 : 8'hB2);
      chk("t4_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      chk("t4_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("t4_drain_a", rf_wdata, 8'hA1);
    step();
    chk("t4_drain_b", rf_wdata, 8'hB2);
    step();
    chk("t4_drain_idle", rf_we, 0);

    // Flush with both buffers full: nothing is written, and requests during the flush are ignored.
    do_reset();
    a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h55;
    b_valid = 1'b1; b_addr = 2'd2; b_data = 8'h66;
    step();
`ifdef RF_WR_ARB_SCOREBOARD_EN
    chk("t5_pend_full", pending, 4'b0110);
`endif
    b_valid = 1'b0;
    a_addr = 2'd3; a_data = 8'h99;
    flush = 1'b1;
    #1;
    chk("t5_a_ready_fl", a_ready, 0);
    chk("t5_b_ready_fl", b_ready, 0);
    step();
    flush = 1'b0; a_valid = 1'b0;
    chk("t5_we_fl", rf_we, 0);
    #1;
    chk("t5_a_ready_after", a_ready, 1);
    chk("t5_b_ready_after", b_ready, 1);
`ifdef RF_WR_ARB_SCOREBOARD_EN
    chk("t5_pend_clr", pending, 0);
`endif
    step();
    chk("t5_we_after", rf_we, 0);
    chk("t5_wdata_after", rf_wdata, 0);

    // Asynchronous reset while a write sits in the output stage.
    do_reset();
    a_valid = 1'b1; a_addr = 2'd3; a_data = 8'h77;
    step();
    a_valid = 1'b0;
    step();
    chk("t6_we_before", rf_we, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_we_rst", rf_we, 0);
    chk("t6_waddr_rst", rf_waddr, 0);
    chk("t6_wdata_rst", rf_wdata, 0);
`ifdef RF_WR_ARB_SCOREBOARD_EN
    chk("t6_pend_rst", pending, 0);
`endif
    step();
    chk("t6_rf3_kept", rf_model[3], 8'h43);
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the register file's single write port between two writeback requesters: ALU result (port A) and load/memory result (port B).
- Each requester has a valid/ready handshake into a one-entry holding buffer. A two-way round-robin arbiter picks one buffer per cycle.
- The granted write is registered onto the register file's write-enable, address and data inputs.
- Sits between the execute/memory stages and the register file; drives the register file's write port directly.

## Interface

Parameters:
- DATA_W, 8, width of write data; matches register file word width.
- ADDR_W, 2, width of register address; 2**ADDR_W registers.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; drops both holding buffers.
- a_valid  input  1  port A write request.
- a_ready  output  1  port A buffer can accept this cycle.
- a_addr  input  ADDR_W  port A destination register.
- a_data  input  DATA_W  port A write data.
- b_valid, b_ready, b_addr, b_data: same definitions, for port B.
- rf_we  output  1  register file write enable.
- rf_waddr  output  ADDR_W  register file write address.
- rf_wdata  output  DATA_W  register file write data.
- Only with RF_WR_ARB_SCOREBOARD_EN: pending  output  2**ADDR_W  per-register in-flight write flags.

## Operation

- Per-port holding buffer: valid bit, addr, data. A transfer occurs on a rising edge where x_valid && x_ready.
- x_ready = !buf_x_v || grant_x. A port may refill on the same edge its buffer drains, giving back-to-back accepts.
- Arbitration is combinational over buffer valid bits:
  - Only one buffer valid: that buffer is granted.
  - Both valid: the port not granted last time wins.
  - last_grant updates only on an actual grant.
  - After reset, last_grant = B, so A wins the first conflict.
- Output stage loads on every edge:
  - rf_we is 1 if any grant occurred, else 0.
  - rf_waddr and rf_wdata load from the granted buffer on a grant; otherwise they hold their previous values.
- No coalescing. Both ports targeting the same register commit in grant order; the later grant overwrites.
- Flush:
  - Clears both buffer valid bits.
  - Forces rf_we = 0 on that edge and suppresses grants in that cycle.
  - Ignores x_valid in that cycle (x_ready = 0 while flush = 1).
  - An output-stage write already registered is unaffected and completes.
- Reset (asynchronous, any time):
  - Buffers invalid, rf_we = 0, rf_waddr = 0, rf_wdata = 0, last_grant = B, pending = 0.
  - A write in flight is discarded.
- Reset values of outputs with reset_n = 0: a_ready = 1, b_ready = 1 (combinational from the empty buffers).

## Timing

- Edge E0: request accepted into its buffer.
- Cycle after E0: buffer arbitrated.
- Edge E1: rf_we, rf_waddr and rf_wdata are registered.
- Edge E2: register file updates.
- Accept-to-update latency: 2 edges with no contention, plus 1 edge per lost arbitration.
- Throughput: 1 register write per cycle total.
  - Under sustained dual requests, each port gets 1 write per 2 cycles, strictly alternating.
- A port holding valid while not ready must keep addr and data stable. The block samples them only on the accepting edge.

## Configuration

- RF_WR_ARB_SCOREBOARD_EN defined:
  - Adds the pending output, registered.
  - pending[i] = 1 when either holding buffer or the output stage (rf_we = 1) holds a write to register i.
  - It is updated on the same edges as those holders.
  - Flush clears the buffer contributions; reset clears all bits.
- RF_WR_ARB_SCOREBOARD_EN undefined: the pending port and its logic are absent; everything else is identical.

## Structure

- Shared package regfile_pkg holds:
  - REG_ADDR_W = 2, REG_DATA_W = 8, NUM_REGS = 4.
  - Requester id constants REQ_A = 0, REQ_B = 1.
- One sub-module: rr_arbiter2. It takes two request bits and produces a one-hot grant, holding the last_grant state.
- The holding buffers and output stage stay in the top module.

## Test plan

- Reset, then a_valid with a_addr = 2, a_data = 0x5A at E0 -> rf_we = 1, rf_waddr = 2, rf_wdata = 0x5A after E1; rf_we = 0 after E2.
- A (addr 1, 0x11) and B (addr 3, 0x33) accepted on the same edge -> A commits first, then B on the next cycle. Repeat both -> B then A.
- A and B both write addr 0 (A = 0xAA, B = 0xBB) on the same edge after reset -> commit order A then B; the register ends at 0xBB.
- Sustained a_valid = b_valid = 1 for 8 cycles -> rf_we stays high and grants alternate A/B; each port sees ready every other cycle.
- Flush asserted with both buffers full -> no rf_we on the following edge, both readies high afterward, and both buffered writes never appear.
- reset_n pulsed low mid-transfer with an output write registered -> rf_we = 0 immediately, and the write does not reach the register file. With RF_WR_ARB_SCOREBOARD_EN, pending = 0 immediately.
